// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: ROM port, decode-side instruction port and
// redirect/stall inputs from downstream.
//   master : the fetch unit (drives ROM address/read and the instruction port)
//   slave  : ROM plus decode/execute stages
`timescale 1ns/1ps
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned OFF_W = 6;

  // ROM port
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rd;
  logic [DATA_W-1:0] rom_data;

  // Instruction port to decode
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_plus1;

  // Backpressure and redirects
  logic              stall;
  logic              br_taken;
  logic [ADDR_W-1:0] br_base_pc;
  logic [OFF_W-1:0]  br_offset;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;

  modport master (
    output rom_addr, rom_rd, instr, instr_valid, pc_out, pc_plus1,
    input  rom_data, stall, br_taken, br_base_pc, br_offset, jump_en, jump_addr
  );

  modport slave (
    input  rom_addr, rom_rd, instr, instr_valid, pc_out, pc_plus1,
    output rom_data, stall, br_taken, br_base_pc, br_offset, jump_en, jump_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a synchronous ROM and presents
// one instruction per cycle to decode. Handles downstream stall and PC
// redirects (taken branch / jump), inserting a NOP bubble for the wrong path.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - fetch_unit_if.master: ROM port, instruction port, stall/redirects
`timescale 1ns/1ps
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 12,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  localparam int unsigned OFF_W = 6;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] issued_pc;
  logic              issued_valid;
  logic [DATA_W-1:0] hold_q;
  logic              hold_sel;

  logic              redirect_c;
  logic [ADDR_W-1:0] br_target_c;
  logic [ADDR_W-1:0] target_c;

  // Redirect target; jump has priority over a simultaneous branch
  assign redirect_c  = bus.br_taken | bus.jump_en;
  assign br_target_c = bus.br_base_pc + ADDR_W'(1)
                     + {{(ADDR_W-OFF_W){bus.br_offset[OFF_W-1]}}, bus.br_offset};
  assign target_c    = bus.jump_en ? bus.jump_addr : br_target_c;

  // State, PC and issue registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      fetch_pc     <= RESET_PC;
      issued_pc    <= '0;
      issued_valid <= 1'b0;
      hold_q       <= '0;
      hold_sel     <= 1'b0;
    end else if (state == BOOT) begin
      state <= RUN;
    end else if (redirect_c) begin
      fetch_pc     <= target_c;
      issued_valid <= 1'b0;
      hold_sel     <= 1'b0;
      state        <= FLUSH;
    end else if (bus.stall) begin
      // ROM read is suppressed while stalled; capture the presented word once
      if (state != FLUSH) begin
        if (!hold_sel) begin
          hold_q   <= bus.rom_data;
          hold_sel <= 1'b1;
        end
        state <= STALL;
      end
    end else begin
      issued_pc    <= fetch_pc;
      issued_valid <= 1'b1;
      fetch_pc     <= fetch_pc + ADDR_W'(1);
      hold_sel     <= 1'b0;
      state        <= RUN;
    end
  end

  // ROM and decode-side outputs
  assign bus.rom_rd      = (state != BOOT) && !bus.stall;
  assign bus.rom_addr    = fetch_pc;
  assign bus.instr       = !issued_valid ? NOP_WORD
                         : (hold_sel ? hold_q : bus.rom_data);
  assign bus.instr_valid = issued_valid;
  assign bus.pc_out      = issued_pc;
  assign bus.pc_plus1    = issued_pc + ADDR_W'(1);

endmodule
